gray_to_binary_stream: RTL and testbench

//  Streaming Gray-to-binary decoder. It is the receive-side counterpart of the binary-to-Gray encoder.

---
 rtl/gray_pkg.sv | 29 ++
 rtl/gray_to_binary_stream_if.sv | 24 ++
 rtl/gray_pipe_stage.sv | 47 ++++
 rtl/gray_to_binary_stream.sv | 82 ++++++++
 tb/tb_gray_to_binary_stream.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Purpose: shared Gray-code helpers for the decoder and the encoder tests.
//   gray2bin : Gray -> binary on a zero-extended word (upper zeros do not change the result)
//   popcount : number of set bits, used by the single-bit-step check
package gray_pkg;

    localparam int unsigned STAGES_MAX = 4;
    localparam int unsigned GRAY_W_MAX = 32;
    localparam int unsigned CNT_W      = 6;

    // bin[i] is the XOR of g[MSB:i]
    function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
        logic [GRAY_W_MAX-1:0] b;
        b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
        for (int i = int'(GRAY_W_MAX) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [GRAY_W_MAX-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(GRAY_W_MAX); i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/gray_to_binary_stream_if.sv
// Purpose: valid/ready stream bundle for the Gray decoder.
//   slave  : decoder view (consumes in_*, produces out_*, sees out_ready)
//   master : environment view (drives in_* and out_ready)
interface gray_to_binary_stream_if #(
    parameter int unsigned N = 8
);
    logic [N-1:0] in_gray;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_bin;
    logic         out_err;
    logic         out_valid;
    logic         out_ready;

    modport slave (
        input  in_gray, in_valid, out_ready,
        output in_ready, out_bin, out_err, out_valid
    );

    modport master (
        output in_gray, in_valid, out_ready,
        input  in_ready, out_bin, out_err, out_valid
    );
endinterface

// File: rtl/gray_pipe_stage.sv
// Purpose: one valid/ready register slice carrying a W-bit payload.
//   in_valid/in_data/in_ready    : upstream side (in_ready = this slice loads this cycle)
//   out_valid/out_data/out_ready : downstream side (out_ready = next slice loads / sink drains)
module gray_pipe_stage #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    // Load when empty or when the contents move on this cycle; bubbles collapse.
    assign in_ready = ~valid_q | out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            // Payload only changes when a real word arrives.
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/gray_to_binary_stream.sv
// Purpose: streaming Gray-to-binary decoder with a Gray continuity check.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave stream port (in_gray/in_valid/in_ready in, out_bin/out_err/out_valid/out_ready out)
// Decode and step check happen before stage 0; {err,bin} then flows through STAGES slices.
// N must not exceed GRAY_W_MAX; STAGES must lie in 1..STAGES_MAX.
module gray_to_binary_stream
    import gray_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned STAGES     = 2,
    parameter bit          ALLOW_HOLD = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    gray_to_binary_stream_if.slave  bus
);
    localparam int unsigned W = N + 1;

    logic [N-1:0]     prev_q, prev_d;
    logic             first_q, first_d;
    logic [N-1:0]     bin_c;
    logic [CNT_W-1:0] diff_cnt;
    logic             step_err;
    logic             in_xfer;

    logic             stg_valid [STAGES+1];
    logic             stg_ready [STAGES+1];
    logic [W-1:0]     stg_data  [STAGES+1];

    // Decode and step check on the incoming word.
    always_comb begin
        bin_c    = N'(gray2bin(GRAY_W_MAX'(bus.in_gray)));
        diff_cnt = popcount(GRAY_W_MAX'(bus.in_gray ^ prev_q));
        // The first word after reset has no predecessor to compare against.
        step_err = ~first_q & ((diff_cnt > CNT_W'(1)) | ((diff_cnt == '0) & ~ALLOW_HOLD));
    end

    assign in_xfer = bus.in_valid & stg_ready[0];

    // Previous-word tracking advances only on accepted words.
    always_comb begin
        prev_d  = prev_q;
        first_d = first_q;
        if (in_xfer) begin
            prev_d  = bus.in_gray;
            first_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= '0;
            first_q <= 1'b1;
        end else begin
            prev_q  <= prev_d;
            first_q <= first_d;
        end
    end

    // Stage chain: index 0 is the input side, index STAGES the output side.
    assign stg_valid[0]      = bus.in_valid;
    assign stg_data[0]       = {step_err, bin_c};
    assign stg_ready[STAGES] = bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        gray_pipe_stage #(.W(W)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (stg_valid[k]),
            .in_data   (stg_data[k]),
            .in_ready  (stg_ready[k]),
            .out_valid (stg_valid[k+1]),
            .out_data  (stg_data[k+1]),
            .out_ready (stg_ready[k+1])
        );
    end

    assign bus.in_ready               = stg_ready[0];
    assign bus.out_valid              = stg_valid[STAGES];
    assign {bus.out_err, bus.out_bin} = stg_data[STAGES];

endmodule

// File: tb/tb_gray_to_binary_stream.sv
// Bench for gray_to_binary_stream: four instances (defaults, ALLOW_HOLD=0, STAGES=1, STAGES=4).
module tb_gray_to_binary_stream;

    logic clk;
    logic rst;

    logic [7:0] drv_gray  [4];
    logic       drv_valid [4];
    logic       drv_ordy  [4];
    logic       mon_irdy  [4];
    logic       mon_ovalid[4];
    logic       mon_oerr  [4];
    logic [7:0] mon_obin  [4];

    int n_checks;
    int n_pass;

    typedef struct {
        logic [7:0] g;
        logic [7:0] b;
        logic       e;
    } vec_t;

    typedef struct packed {
        logic [7:0] b;
        logic       e;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    logic [7:0] m_prev;
    logic       m_first;

    gray_to_binary_stream_if #(.N(8)) bus0 ();
    gray_to_binary_stream_if #(.N(8)) bus1 ();
    gray_to_binary_stream_if #(.N(8)) bus2 ();
    gray_to_binary_stream_if #(.N(8)) bus3 ();

    gray_to_binary_stream #(.N(8), .STAGES(2), .ALLOW_HOLD(1'b1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    gray_to_binary_stream #(.N(8), .STAGES(2), .ALLOW_HOLD(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    gray_to_binary_stream #(.N(8), .STAGES(1), .ALLOW_HOLD(1'b1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    gray_to_binary_stream #(.N(8), .STAGES(4), .ALLOW_HOLD(1'b1)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    assign bus0.in_gray = drv_gray[0]; assign bus0.in_valid = drv_valid[0]; assign bus0.out_ready = drv_ordy[0];
    assign bus1.in_gray = drv_gray[1]; assign bus1.in_valid = drv_valid[1]; assign bus1.out_ready = drv_ordy[1];
    assign bus2.in_gray = drv_gray[2]; assign bus2.in_valid = drv_valid[2]; assign bus2.out_ready = drv_ordy[2];
    assign bus3.in_gray = drv_gray[3]; assign bus3.in_valid = drv_valid[3]; assign bus3.out_ready = drv_ordy[3];

    assign mon_irdy[0] = bus0.in_ready; assign mon_ovalid[0] = bus0.out_valid; assign mon_oerr[0] = bus0.out_err; assign mon_obin[0] = bus0.out_bin;
    assign mon_irdy[1] = bus1.in_ready; assign mon_ovalid[1] = bus1.out_valid; assign mon_oerr[1] = bus1.out_err; assign mon_obin[1] = bus1.out_bin;
    assign mon_irdy[2] = bus2.in_ready; assign mon_ovalid[2] = bus2.out_valid; assign mon_oerr[2] = bus2.out_err; assign mon_obin[2] = bus2.out_bin;
    assign mon_irdy[3] = bus3.in_ready; assign mon_ovalid[3] = bus3.out_valid; assign mon_oerr[3] = bus3.out_err; assign mon_obin[3] = bus3.out_bin;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gray_of(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB via doubling shifts.
    function automatic logic [7:0] ref_bin(input logic [7:0] g);
        logic [7:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        return b;
    endfunction

    function automatic logic hold_cfg(input int idx);
        return (idx != 1);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_reset();
        sbq.delete();
        m_prev  = 8'h00;
        m_first = 1'b1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 4; i++) begin
            drv_gray[i]  = 8'h00;
            drv_valid[i] = 1'b0;
            drv_ordy[i]  = 1'b0;
        end
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock of traffic on DUT idx with scoreboard bookkeeping. Entered and left at posedge+1.
    task automatic step(input int idx, input logic v, input logic [7:0] g, input logic ordy, output logic acc);
        int d;
        sb_t e;
        sb_t n;
        drv_valid[idx] = v;
        drv_gray[idx]  = g;
        drv_ordy[idx]  = ordy;
        #1;
        acc = v & mon_irdy[idx];
        if (mon_ovalid[idx] && ordy) begin
            if (sbq.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected dut%0d: got word %0h expected none", idx, mon_obin[idx]);
            end else begin
                e = sbq.pop_front();
                check($sformatf("sb_bin dut%0d", idx), 32'(mon_obin[idx]), 32'(e.b));
                check($sformatf("sb_err dut%0d", idx), 32'(mon_oerr[idx]), 32'(e.e));
            end
        end
        if (acc) begin
            d = $countones(g ^ m_prev);
            n.b = ref_bin(g);
            n.e = !m_first && ((d > 1) || (d == 0 && !hold_cfg(idx)));
            sbq.push_back(n);
            m_prev  = g;
            m_first = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int idx);
        logic acc;
        for (int c = 0; c < 40 && sbq.size() > 0; c++) step(idx, 1'b0, 8'h00, 1'b1, acc);
        check($sformatf("drain_left dut%0d", idx), 32'(sbq.size()), 32'd0);
        drv_ordy[idx] = 1'b0;
    endtask

    // Streams vecs back to back with out_ready=1 and checks each word exactly lat edges after acceptance.
    task automatic run_table(input int idx, input int lat, input string tag);
        int n;
        int j;
        n = vecs.size();
        for (int i = 0; i < n + lat; i++) begin
            drv_ordy[idx]  = 1'b1;
            drv_valid[idx] = (i < n);
            drv_gray[idx]  = (i < n) ? vecs[i].g : 8'h00;
            #1;
            if (i < n) check($sformatf("%s in_ready[%0d]", tag, i), 32'(mon_irdy[idx]), 32'd1);
            @(posedge clk);
            #1;
            j = i - lat;
            if (j >= 0 && j < n) begin
                check($sformatf("%s out_valid[%0d]", tag, j), 32'(mon_ovalid[idx]), 32'd1);
                check($sformatf("%s out_bin[%0d]", tag, j), 32'(mon_obin[idx]), 32'(vecs[j].b));
                check($sformatf("%s out_err[%0d]", tag, j), 32'(mon_oerr[idx]), 32'(vecs[j].e));
            end
        end
        drv_valid[idx] = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("%s empty_after", tag), 32'(mon_ovalid[idx]), 32'd0);
        drv_ordy[idx] = 1'b0;
    endtask

    task automatic rand_test(input int idx, input int nwords);
        logic [7:0] cnt;
        logic [7:0] g;
        logic       v;
        logic       acc;
        logic       pending;
        int         got;
        int         cyc;
        int         r;
        cnt = 8'h00;
        g = 8'h00;
        v = 1'b0;
        pending = 1'b0;
        got = 0;
        cyc = 0;
        while (got < nwords && cyc < 30000) begin
            if (!pending) begin
                r = $urandom_range(0, 9);
                if (r < 6)      cnt = cnt + 8'd1;
                else if (r < 8) cnt = cnt;
                else            cnt = 8'($urandom_range(0, 255));
                g = gray_of(cnt);
                v = ($urandom_range(0, 3) != 0);
            end
            step(idx, v, g, ($urandom_range(0, 2) != 0), acc);
            // Hold an offered word until it is taken.
            pending = v && !acc;
            if (acc) got++;
            cyc++;
        end
        check($sformatf("rand_words dut%0d", idx), 32'(got), 32'(nwords));
        drain(idx);
    endtask

    initial begin
        logic acc;
        n_checks = 0;
        n_pass   = 0;
        idle_all();
        model_reset();
        rst = 1'b1;

        // Reset state on every instance.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst out_valid dut%0d", i), 32'(mon_ovalid[i]), 32'd0);
            check($sformatf("rst out_bin dut%0d", i), 32'(mon_obin[i]), 32'd0);
            check($sformatf("rst out_err dut%0d", i), 32'(mon_oerr[i]), 32'd0);
            check($sformatf("rst in_ready dut%0d", i), 32'(mon_irdy[i]), 32'd1);
        end

        // Exhaustive decode of Gray(0..255), one word per cycle.
        vecs.delete();
        for (int i = 0; i < 256; i++) vecs.push_back('{gray_of(8'(i)), 8'(i), 1'b0});
        run_table(0, 1, "exh");

        // Spot values, wrap-around and step errors.
        do_reset();
        vecs.delete();
        vecs.push_back('{8'h0C, 8'h08, 1'b0});
        vecs.push_back('{8'h80, 8'hFF, 1'b1});
        vecs.push_back('{8'h01, 8'h01, 1'b1});
        vecs.push_back('{8'h80, 8'hFF, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b0});
        vecs.push_back('{8'h00, 8'h00, 1'b0});
        vecs.push_back('{8'h01, 8'h01, 1'b0});
        vecs.push_back('{8'h03, 8'h02, 1'b0});
        vecs.push_back('{8'h00, 8'h00, 1'b1});
        run_table(0, 1, "spot");

        // Repeated word is an error when holds are not allowed.
        vecs.delete();
        vecs.push_back('{8'h05, 8'h06, 1'b0});
        vecs.push_back('{8'h05, 8'h06, 1'b1});
        vecs.push_back('{8'h04, 8'h07, 1'b0});
        run_table(1, 1, "hold0");

        // Backpressure: five cycles of out_ready=0 while the source keeps offering.
        do_reset();
        step(0, 1'b1, gray_of(8'd5), 1'b0, acc);
        check("bp accept0", 32'(acc), 32'd1);
        step(0, 1'b1, gray_of(8'd6), 1'b0, acc);
        check("bp accept1", 32'(acc), 32'd1);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("bp stall_valid[%0d]", s), 32'(mon_ovalid[0]), 32'd1);
            check($sformatf("bp stall_bin[%0d]", s), 32'(mon_obin[0]), 32'h05);
            step(0, 1'b1, gray_of(8'd7), 1'b0, acc);
            check($sformatf("bp in_ready_low[%0d]", s), 32'(acc), 32'd0);
        end
        // Full pipeline with input and output transfer in the same cycle.
        step(0, 1'b1, gray_of(8'd7), 1'b1, acc);
        check("bp full_passthru", 32'(acc), 32'd1);
        for (int k = 8; k < 16; k++) begin
            acc = 1'b0;
            for (int c = 0; c < 10 && !acc; c++) step(0, 1'b1, gray_of(8'(k)), 1'b1, acc);
            check($sformatf("bp accept_k%0d", k), 32'(acc), 32'd1);
        end
        drain(0);

        // Reset with two words in flight; they must never appear.
        step(0, 1'b1, gray_of(8'd20), 1'b0, acc);
        step(0, 1'b1, gray_of(8'd21), 1'b0, acc);
        check("mr full", 32'(mon_irdy[0]), 32'd0);
        idle_all();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("mr out_valid", 32'(mon_ovalid[0]), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step(0, 1'b0, 8'h00, 1'b1, acc);
            check($sformatf("mr idle_valid[%0d]", c), 32'(mon_ovalid[0]), 32'd0);
        end
        step(0, 1'b1, 8'hFF, 1'b1, acc);
        check("mr accept_ff", 32'(acc), 32'd1);
        drain(0);

        // Random valid/ready traffic on the shallowest and deepest pipelines.
        do_reset();
        rand_test(2, 3000);
        do_reset();
        rand_test(3, 3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
